// File: rtl/dvp_tx_if.sv
// Pixel-stream input and DVP bus output bundle for the dvp_tx camera model.
// The pixel source is the master; dvp_tx is the slave.
interface dvp_tx_if;
    logic [15:0] pixel;
    logic        pixel_vld;
    logic        pixel_sop;
    logic        pixel_eop;
    logic        pixel_rdy;
    logic        cmos_vsync;
    logic        cmos_href;
    logic [7:0]  cmos_dout;
    logic        frame_done;
    logic        underrun;
    logic        err;

    modport master (
        output pixel, pixel_vld, pixel_sop, pixel_eop,
        input  pixel_rdy, cmos_vsync, cmos_href, cmos_dout,
        input  frame_done, underrun, err
    );

    modport slave (
        input  pixel, pixel_vld, pixel_sop, pixel_eop,
        output pixel_rdy, cmos_vsync, cmos_href, cmos_dout,
        output frame_done, underrun, err
    );
endinterface

// File: rtl/dvp_tx.sv
// DVP transmitter: serialises a 16-bit pixel packet stream onto an 8-bit
// camera bus with vsync/href framing, high byte first.
module dvp_tx #(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int VSYNC_LEN = 50,
    parameter int VBP       = 50,
    parameter int HBLANK    = 10,
    parameter int VFP       = 50
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    tx_en,
    dvp_tx_if.slave bus
);
    function automatic int cw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int TW = max2(max2(cw(VSYNC_LEN), cw(VBP)), max2(cw(HBLANK), cw(VFP)));
    localparam int SW = cw(2 * IMG_W);
    localparam int LW = cw(IMG_H);
    localparam int PW = cw(IMG_W * IMG_H);

    localparam logic [TW-1:0] VS_LAST   = TW'(VSYNC_LEN - 1);
    localparam logic [TW-1:0] VBP_LAST  = TW'(VBP - 1);
    localparam logic [TW-1:0] HB_LAST   = TW'(HBLANK - 1);
    localparam logic [TW-1:0] VFP_LAST  = TW'(VFP - 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(2 * IMG_W - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(IMG_H - 1);
    localparam logic [PW-1:0] PIX_LAST  = PW'(IMG_W * IMG_H - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBP,
        S_LINE,
        S_HBLANK,
        S_VFP
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [LW-1:0] line_q, line_d;
    logic [PW-1:0] pix_q, pix_d;
    logic          drain_q, drain_d;
    logic          first_q, first_d;
    logic [7:0]    lo_q, lo_d;

    logic          vsync_q, vsync_d;
    logic          href_q, href_d;
    logic [7:0]    dout_q, dout_d;
    logic          done_q, done_d;
    logic          und_q, und_d;
    logic          err_q, err_d;

    logic          rdy;
    logic          frame_start;
    logic          start;

    assign frame_start = tx_en & bus.pixel_vld & bus.pixel_sop;

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        slot_d  = slot_q;
        line_d  = line_q;
        pix_d   = pix_q;
        drain_d = drain_q;
        first_d = first_q;
        lo_d    = lo_q;
        vsync_d = 1'b0;
        href_d  = 1'b0;
        dout_d  = '0;
        done_d  = 1'b0;
        und_d   = 1'b0;
        err_d   = 1'b0;
        rdy     = 1'b0;
        start   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Non-sop pixels are swallowed to resync; the sop pixel stays put.
                rdy = tx_en & ~bus.pixel_sop;
                if (frame_start) begin
                    start = 1'b1;
                end
            end

            S_VSYNC: begin
                vsync_d = 1'b1;
                if (tmr_q == VS_LAST) begin
                    state_d = S_VBP;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end

            S_VBP: begin
                if (tmr_q == VBP_LAST) begin
                    state_d = S_LINE;
                    tmr_d   = '0;
                    slot_d  = '0;
                    line_d  = '0;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end

            S_LINE: begin
                href_d = 1'b1;
                if (!slot_q[0]) begin
                    rdy   = ~drain_q;
                    pix_d = pix_q + PW'(1);
                    if (drain_q) begin
                        lo_d = '0;
                    end else if (bus.pixel_vld) begin
                        dout_d  = bus.pixel[15:8];
                        lo_d    = bus.pixel[7:0];
                        first_d = 1'b0;
                        if (bus.pixel_sop && !first_q) begin
                            err_d = 1'b1;
                        end
                        // Early eop blanks the rest of the frame so the next
                        // frame's pixels are left in the stream.
                        if (pix_q == PIX_LAST) begin
                            if (!bus.pixel_eop) begin
                                err_d = 1'b1;
                            end
                        end else if (bus.pixel_eop) begin
                            err_d   = 1'b1;
                            drain_d = 1'b1;
                        end
                    end else begin
                        und_d = 1'b1;
                        lo_d  = '0;
                    end
                end else begin
                    dout_d = lo_q;
                end

                if (slot_q == SLOT_LAST) begin
                    state_d = S_HBLANK;
                    tmr_d   = '0;
                end else begin
                    slot_d = slot_q + SW'(1);
                end
            end

            S_HBLANK: begin
                if (tmr_q == HB_LAST) begin
                    tmr_d = '0;
                    if (line_q == LINE_LAST) begin
                        state_d = S_VFP;
                    end else begin
                        state_d = S_LINE;
                        line_d  = line_q + LW'(1);
                        slot_d  = '0;
                    end
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end

            S_VFP: begin
                if (tmr_q == VFP_LAST) begin
                    done_d = 1'b1;
                    // A waiting sop is taken here so vsync directly follows
                    // frame_done on the bus instead of idling one extra cycle.
                    if (frame_start) begin
                        start = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        tmr_d   = '0;
                    end
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                tmr_d   = '0;
            end
        endcase

        if (start) begin
            state_d = S_VSYNC;
            tmr_d   = '0;
            slot_d  = '0;
            line_d  = '0;
            pix_d   = '0;
            drain_d = 1'b0;
            first_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            slot_q  <= '0;
            line_q  <= '0;
            pix_q   <= '0;
            drain_q <= 1'b0;
            first_q <= 1'b0;
            lo_q    <= '0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            und_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            slot_q  <= slot_d;
            line_q  <= line_d;
            pix_q   <= pix_d;
            drain_q <= drain_d;
            first_q <= first_d;
            lo_q    <= lo_d;
            vsync_q <= vsync_d;
            href_q  <= href_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            und_q   <= und_d;
            err_q   <= err_d;
        end
    end

    assign bus.pixel_rdy  = rdy & rst_n;
    assign bus.cmos_vsync = vsync_q;
    assign bus.cmos_href  = href_q;
    assign bus.cmos_dout  = dout_q;
    assign bus.frame_done = done_q;
    assign bus.underrun   = und_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_dvp_tx.sv
// Scoreboard bench for dvp_tx: frames queued as stimulus carry their expected
// byte stream and pulse positions; a bus monitor checks them frame by frame.
module tb_dvp_tx;
    localparam int W        = 4;
    localparam int H        = 2;
    localparam int VS       = 3;
    localparam int VB       = 2;
    localparam int HB       = 2;
    localparam int VF       = 2;
    localparam int LINE_CYC = 2 * W + HB;
    localparam int FLEN     = VS + VB + H * LINE_CYC + VF;
    localparam int NB       = 2 * W * H;

    typedef struct {
        logic [15:0] d;
        bit          sop;
        bit          eop;
        int          gap;
    } pix_t;

    typedef struct {
        logic [NB-1:0][7:0] b;
        int                 n_err;
        int                 err_at;
        int                 n_und;
        int                 und_at;
        bit                 b2b;
    } rec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic tx_en = 1'b0;

    dvp_tx_if bus ();

    dvp_tx #(
        .IMG_W    (W),
        .IMG_H    (H),
        .VSYNC_LEN(VS),
        .VBP      (VB),
        .HBLANK   (HB),
        .VFP      (VF)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .tx_en(tx_en),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int   n_tests     = 0;
    int   n_fail      = 0;
    int   frames_done = 0;
    bit   in_frame    = 1'b0;
    int   off         = 0;
    pix_t src_q[$];
    rec_t rec_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic wait_frames(input int n);
        int t;
        t = 0;
        while (frames_done < n && t < 400) begin
            @(posedge clk);
            t++;
        end
        #3;
        chk("frame_count", 32'(frames_done), 32'(n));
    endtask

    task automatic wait_offset(input int o);
        int t;
        t = 0;
        while (!(in_frame && off >= o) && t < 200) begin
            @(posedge clk);
            #3;
            t++;
        end
        chk("reach_offset", 32'(in_frame), 1);
    endtask

    task automatic push_frame(input logic [7:0] base, input int npix, input int eop_at,
                              input int gap_at);
        for (int i = 0; i < npix; i++) begin
            pix_t p;
            p.d   = {base + 8'(2 * i), base + 8'(2 * i + 1)};
            p.sop = (i == 0);
            p.eop = (i == eop_at);
            p.gap = (i == gap_at) ? 2 : 0;
            src_q.push_back(p);
        end
    endtask

    function automatic rec_t mk_rec(input logic [7:0] base, input bit b2b);
        rec_t r;
        for (int i = 0; i < NB; i++) r.b[i] = base + 8'(i);
        r.n_err  = 0;
        r.err_at = -1;
        r.n_und  = 0;
        r.und_at = -1;
        r.b2b    = b2b;
        return r;
    endfunction

    // Pixel source: offers the queue head each cycle, honouring per-pixel gaps.
    initial begin : source
        bit head_started;
        int gap_left;
        head_started  = 1'b0;
        gap_left      = 0;
        bus.pixel     = '0;
        bus.pixel_vld = 1'b0;
        bus.pixel_sop = 1'b0;
        bus.pixel_eop = 1'b0;
        forever begin
            @(negedge clk);
            bus.pixel_vld = 1'b0;
            bus.pixel_sop = 1'b0;
            bus.pixel_eop = 1'b0;
            if (src_q.size() > 0) begin
                if (!head_started) begin
                    gap_left     = src_q[0].gap;
                    head_started = 1'b1;
                end
                if (gap_left > 0) begin
                    gap_left--;
                end else begin
                    bus.pixel     = src_q[0].d;
                    bus.pixel_sop = src_q[0].sop;
                    bus.pixel_eop = src_q[0].eop;
                    bus.pixel_vld = 1'b1;
                end
            end else begin
                head_started = 1'b0;
            end
            #1;
            if (bus.pixel_vld && bus.pixel_rdy && src_q.size() > 0) begin
                void'(src_q.pop_front());
                head_started = 1'b0;
            end
        end
    end

    // Bus monitor: checks framing timing and bytes against the popped record.
    initial begin : monitor
        rec_t cur;
        int   cyc, fd_cyc, bidx, n_err, n_und, rel;
        bit   prev_vs, e_vs, e_href, e_fd;
        cur     = mk_rec(8'h00, 1'b0);
        cyc     = 0;
        fd_cyc  = -100;
        bidx    = 0;
        n_err   = 0;
        n_und   = 0;
        prev_vs = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                chk("rst_outputs",
                    32'({bus.cmos_vsync, bus.cmos_href, bus.cmos_dout, bus.frame_done,
                         bus.underrun, bus.err, bus.pixel_rdy}), 0);
                in_frame = 1'b0;
                prev_vs  = 1'b0;
            end else begin
                if (bus.cmos_vsync && !prev_vs && !in_frame) begin
                    if (rec_q.size() == 0) begin
                        chk("frame_expected", 0, 1);
                        cur = mk_rec(8'h00, 1'b0);
                    end else begin
                        cur = rec_q.pop_front();
                    end
                    if (cur.b2b) chk("b2b_vsync_gap", 32'(cyc - fd_cyc), 1);
                    in_frame = 1'b1;
                    off      = 0;
                    bidx     = 0;
                    n_err    = 0;
                    n_und    = 0;
                end
                if (in_frame) begin
                    rel    = off - VS - VB;
                    e_vs   = (off < VS);
                    e_href = (rel >= 0) && (rel < H * LINE_CYC) && ((rel % LINE_CYC) < 2 * W);
                    e_fd   = (off == FLEN - 1);
                    chk("vsync", 32'(bus.cmos_vsync), 32'(e_vs));
                    chk("href", 32'(bus.cmos_href), 32'(e_href));
                    chk("frame_done", 32'(bus.frame_done), 32'(e_fd));
                    if (bus.cmos_href) begin
                        if (bidx < NB) chk("dout_byte", 32'(bus.cmos_dout), 32'(cur.b[bidx]));
                        else chk("byte_count", 32'(bidx), NB - 1);
                    end else begin
                        chk("dout_blank", 32'(bus.cmos_dout), 0);
                    end
                    if (bus.underrun) begin
                        n_und++;
                        chk("underrun_pos", 32'(bidx), 32'(cur.und_at));
                    end
                    if (bus.err) begin
                        n_err++;
                        chk("err_pos", 32'(bidx), 32'(cur.err_at));
                    end
                    if (bus.cmos_href) bidx++;
                    off++;
                    if (bus.frame_done) begin
                        chk("err_count", 32'(n_err), 32'(cur.n_err));
                        chk("underrun_count", 32'(n_und), 32'(cur.n_und));
                        chk("bytes_sent", 32'(bidx), NB);
                        fd_cyc   = cyc;
                        in_frame = 1'b0;
                        frames_done++;
                    end else if (off >= FLEN) begin
                        chk("frame_end", 32'(off), FLEN - 1);
                        in_frame = 1'b0;
                    end
                end else begin
                    chk("idle_quiet",
                        32'({bus.cmos_href, bus.cmos_dout, bus.frame_done, bus.underrun,
                             bus.err}), 0);
                end
                prev_vs = bus.cmos_vsync;
            end
        end
    end

    initial begin : main
        rec_t r;
        int   fd0;
        step(3);
        rst_n = 1'b1;
        tx_en = 1'b1;

        // Nominal frame
        push_frame(8'h01, 8, 7, -1);
        rec_q.push_back(mk_rec(8'h01, 1'b0));
        wait_frames(1);
        chk("src_drained_nominal", 32'(src_q.size()), 0);

        // Resync: stray non-sop pixels dropped in idle
        for (int i = 0; i < 3; i++) begin
            pix_t j;
            j.d   = 16'hDEAD;
            j.sop = 1'b0;
            j.eop = 1'b0;
            j.gap = 0;
            src_q.push_back(j);
        end
        push_frame(8'h20, 8, 7, -1);
        rec_q.push_back(mk_rec(8'h20, 1'b0));
        wait_frames(2);
        chk("src_drained_resync", 32'(src_q.size()), 0);

        // Underrun on pixel 5; eop pixel never fits in the frame
        r = mk_rec(8'h01, 1'b0);
        r.b[10] = 8'h00;
        r.b[11] = 8'h00;
        for (int i = 12; i < NB; i++) r.b[i] = 8'h01 + 8'(i - 2);
        r.n_err  = 1;
        r.err_at = 14;
        r.n_und  = 1;
        r.und_at = 10;
        push_frame(8'h01, 8, 7, 5);
        rec_q.push_back(r);
        wait_frames(3);
        step(4);
        chk("src_drained_underrun", 32'(src_q.size()), 0);

        // Early eop on pixel 3, next frame queued behind it starts back to back
        r = mk_rec(8'h40, 1'b0);
        for (int i = 8; i < NB; i++) r.b[i] = 8'h00;
        r.n_err  = 1;
        r.err_at = 6;
        push_frame(8'h40, 4, 3, -1);
        push_frame(8'h60, 8, 7, -1);
        rec_q.push_back(r);
        rec_q.push_back(mk_rec(8'h60, 1'b1));
        wait_frames(5);
        chk("src_drained_eop", 32'(src_q.size()), 0);

        // tx_en dropped during line 1
        push_frame(8'h80, 8, 7, -1);
        rec_q.push_back(mk_rec(8'h80, 1'b0));
        wait_offset(16);
        tx_en = 1'b0;
        wait_frames(6);
        tx_en = 1'b1;

        // Reset during line 0 aborts without frame_done
        push_frame(8'hA0, 8, 7, -1);
        rec_q.push_back(mk_rec(8'hA0, 1'b0));
        wait_offset(8);
        fd0   = frames_done;
        rst_n = 1'b0;
        step(2);
        src_q.delete();
        rec_q.delete();
        tx_en = 1'b0;
        rst_n = 1'b1;
        step(30);
        chk("no_done_after_abort", 32'(frames_done), 32'(fd0));

        // Recovery frame after the abort
        tx_en = 1'b1;
        push_frame(8'h01, 8, 7, -1);
        rec_q.push_back(mk_rec(8'h01, 1'b0));
        wait_frames(fd0 + 1);
        chk("src_drained_recovery", 32'(src_q.size()), 0);

        step(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "simulation time limit reached");
    end
endmodule
